// File: rtl/vram_arb_pkg.sv
// Shared definitions for the VRAM slot arbiter: write-width codes,
// slot-owner encoding and the rotating-priority pick function.
package vram_arb_pkg;

    // Write-width codes, mirroring the shared MEMORY_WIDTH_* defines.
    localparam logic [1:0] MEMORY_WIDTH_8  = 2'b00;
    localparam logic [1:0] MEMORY_WIDTH_16 = 2'b01;
    localparam logic [1:0] MEMORY_WIDTH_32 = 2'b10;

    // Widest channel count the pick function has to cover.
    localparam int MAX_CH = 8;

    typedef enum logic [1:0] {
        OWN_IDLE,
        OWN_DISP,
        OWN_SPRT,
        OWN_CH
    } slot_owner_e;

    // First pending channel at or after ptr, wrapping modulo n.
    // Result is {valid, id[2:0]}. Scans from the farthest offset down so the
    // nearest pending channel is the last one written.
    function automatic logic [3:0] rr_pick(input logic [7:0] pending,
                                           input logic [2:0] ptr,
                                           input int         n);
        logic [3:0] res;
        int         idx;
        res = '0;
        for (int k = MAX_CH - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = (int'(ptr) + k) % n;
                if (pending[idx[2:0]]) begin
                    res = {1'b1, idx[2:0]};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/vram_arb_pick.sv
// Combinational priority picker: fixed (lowest index first) when mode_i=0,
// rotating from ptr_i when mode_i=1.
module vram_arb_pick
    import vram_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ID_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] pending_i,
    input  logic [ID_W-1:0]   ptr_i,
    input  logic              mode_i,
    output logic [ID_W-1:0]   id_o,
    output logic              valid_o
);

    logic [7:0] pend8;
    logic [2:0] ptr3;
    logic [3:0] res;

    // Widen to the function's fixed width; a zero pointer gives fixed priority.
    always_comb begin
        pend8                 = '0;
        pend8[NUM_CH-1:0]     = pending_i;
        ptr3                  = '0;
        ptr3[ID_W-1:0]        = mode_i ? ptr_i : '0;
        res                   = rr_pick(pend8, ptr3, NUM_CH);
        id_o                  = ID_W'(res[2:0]);
        valid_o               = res[3];
    end

endmodule

// File: rtl/vram_slot_arbiter.sv
// VRAM slot arbiter: on each arbitration slot hands the single VRAM port to
// display, sprite, or one of NUM_CH toggle-handshake channels.
module vram_slot_arbiter
    import vram_arb_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 32,
    parameter int ARB_DOT  = 2,
    parameter int MAX_WAIT = 15
) (
    input  logic                       CLK21M,
    input  logic                       RESET_N,
    input  logic [1:0]                 dot_state,
    input  logic                       rr_mode,
    input  logic                       disp_claim,
    input  logic [ADDR_W-1:0]          disp_addr,
    input  logic                       sprt_claim,
    input  logic [ADDR_W-1:0]          sprt_addr,
    input  logic [NUM_CH-1:0]          ch_req,
    output logic [NUM_CH-1:0]          ch_ack,
    input  logic [NUM_CH-1:0]          ch_we,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
    input  logic [NUM_CH*2-1:0]        ch_wsize,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic                       mem_we_n,
    output logic [1:0]                 mem_wr_size,
    output logic                       grant_valid,
    output logic [$clog2(NUM_CH)-1:0]  grant_id
);

    localparam int         ID_W     = $clog2(NUM_CH);
    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    logic [NUM_CH-1:0] ack_q, ack_d;
    logic [NUM_CH-1:0] pend, prom;
    logic [7:0]        wait_q [NUM_CH];
    logic [7:0]        wait_d [NUM_CH];
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic              grant_valid_q, grant_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_n_q, mem_we_n_d;
    logic [1:0]        mem_wr_size_q, mem_wr_size_d;

    logic [ID_W-1:0]   prom_id, norm_id, gid;
    logic              prom_valid, norm_valid, slot;
    slot_owner_e       owner;

    // Pending channels and the subset that has starved up to MAX_WAIT.
    always_comb begin
        pend = ch_req ^ ack_q;
        prom = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            prom[i] = pend[i] && (wait_q[i] == WAIT_MAX);
        end
    end

    vram_arb_pick #(.NUM_CH(NUM_CH), .ID_W(ID_W)) u_pick_prom (
        .pending_i (prom),
        .ptr_i     ('0),
        .mode_i    (1'b0),
        .id_o      (prom_id),
        .valid_o   (prom_valid)
    );

    vram_arb_pick #(.NUM_CH(NUM_CH), .ID_W(ID_W)) u_pick_norm (
        .pending_i (pend),
        .ptr_i     (rr_ptr_q),
        .mode_i    (rr_mode),
        .id_o      (norm_id),
        .valid_o   (norm_valid)
    );

    // Decide who owns the current slot: display, sprite, promoted, normal.
    always_comb begin
        slot  = (dot_state == 2'(ARB_DOT));
        owner = OWN_IDLE;
        gid   = norm_id;
        if (slot) begin
            if (disp_claim) begin
                owner = OWN_DISP;
            end else if (sprt_claim) begin
                owner = OWN_SPRT;
            end else if (prom_valid) begin
                owner = OWN_CH;
                gid   = prom_id;
            end else if (norm_valid) begin
                owner = OWN_CH;
            end
        end
    end

    // Next-state for the VRAM port, handshake, pointer and wait counters.
    always_comb begin
        ack_d         = ack_q;
        wait_d        = wait_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_we_n_d    = 1'b1;
        mem_wr_size_d = mem_wr_size_q;

        case (owner)
            OWN_DISP: mem_addr_d = disp_addr;
            OWN_SPRT: mem_addr_d = sprt_addr;
            OWN_CH: begin
                mem_addr_d = ch_addr[gid*ADDR_W +: ADDR_W];
                if (ch_we[gid]) begin
                    mem_wdata_d   = ch_wdata[gid*DATA_W +: DATA_W];
                    mem_wr_size_d = ch_wsize[gid*2 +: 2];
                    mem_we_n_d    = 1'b0;
                end
                ack_d[gid]    = ~ack_q[gid];
                grant_valid_d = 1'b1;
                grant_id_d    = gid;
                rr_ptr_d      = (gid == ID_W'(NUM_CH - 1)) ? '0 : gid + 1'b1;
            end
            default: ;
        endcase

        // Reserved display/sprite slots are not counted as lost slots.
        if (slot && (owner != OWN_DISP) && (owner != OWN_SPRT)) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!pend[i] || ((owner == OWN_CH) && (gid == ID_W'(i)))) begin
                    wait_d[i] = '0;
                end else if (wait_q[i] != WAIT_MAX) begin
                    wait_d[i] = wait_q[i] + 8'd1;
                end
            end
        end
    end

    // State registers; reset also aborts any in-flight write.
    always_ff @(posedge CLK21M or negedge RESET_N) begin
        if (!RESET_N) begin
            ack_q         <= '0;
            rr_ptr_q      <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            mem_addr_q    <= '1;
            mem_wdata_q   <= '0;
            mem_we_n_q    <= 1'b1;
            mem_wr_size_q <= MEMORY_WIDTH_8;
            for (int i = 0; i < NUM_CH; i++) begin
                wait_q[i] <= '0;
            end
        end else begin
            ack_q         <= ack_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_we_n_q    <= mem_we_n_d;
            mem_wr_size_q <= mem_wr_size_d;
            for (int i = 0; i < NUM_CH; i++) begin
                wait_q[i] <= wait_d[i];
            end
        end
    end

    assign ch_ack      = ack_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_we_n    = mem_we_n_q;
    assign mem_wr_size = mem_wr_size_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Directed self-checking bench for vram_slot_arbiter (4 channels, MAX_WAIT=3).
module tb_vram_slot_arbiter;
    import vram_arb_pkg::*;

    localparam int NUM_CH   = 4;
    localparam int ADDR_W   = 18;
    localparam int DATA_W   = 32;
    localparam int ARB_DOT  = 2;
    localparam int MAX_WAIT = 3;

    logic                      CLK21M;
    logic                      RESET_N;
    logic [1:0]                dot_state;
    logic                      rr_mode;
    logic                      disp_claim;
    logic [ADDR_W-1:0]         disp_addr;
    logic                      sprt_claim;
    logic [ADDR_W-1:0]         sprt_addr;
    logic [NUM_CH-1:0]         ch_req;
    logic [NUM_CH-1:0]         ch_ack;
    logic [NUM_CH-1:0]         ch_we;
    logic [NUM_CH*ADDR_W-1:0]  ch_addr;
    logic [NUM_CH*DATA_W-1:0]  ch_wdata;
    logic [NUM_CH*2-1:0]       ch_wsize;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic                      mem_we_n;
    logic [1:0]                mem_wr_size;
    logic                      grant_valid;
    logic [1:0]                grant_id;

    int                passed = 0;
    int                total  = 0;
    logic [NUM_CH-1:0] exp_ack;
    logic [ADDR_W-1:0] base_addr [NUM_CH];

    vram_slot_arbiter #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .ARB_DOT(ARB_DOT), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .CLK21M(CLK21M), .RESET_N(RESET_N), .dot_state(dot_state), .rr_mode(rr_mode),
        .disp_claim(disp_claim), .disp_addr(disp_addr),
        .sprt_claim(sprt_claim), .sprt_addr(sprt_addr),
        .ch_req(ch_req), .ch_ack(ch_ack), .ch_we(ch_we), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_wsize(ch_wsize),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we_n(mem_we_n),
        .mem_wr_size(mem_wr_size), .grant_valid(grant_valid), .grant_id(grant_id)
    );

    initial CLK21M = 1'b0;
    always #5 CLK21M = ~CLK21M;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic set_ch(input int i, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [1:0] s);
        ch_we[i]                    = we;
        ch_addr[i*ADDR_W +: ADDR_W] = a;
        ch_wdata[i*DATA_W +: DATA_W] = d;
        ch_wsize[i*2 +: 2]          = s;
    endtask

    task automatic slot_begin();
        @(negedge CLK21M);
        dot_state = 2'(ARB_DOT);
    endtask

    task automatic slot_end();
        @(negedge CLK21M);
        dot_state = 2'd0;
    endtask

    task automatic do_slot();
        slot_begin();
        slot_end();
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        ch_req  = 4'b0001;
        exp_ack = '0;
        repeat (2) do_slot();
        total++; if (ch_ack !== 4'b0000) $display("FAIL rst_ack got %b exp 0000", ch_ack); else passed++;
        total++; if (mem_we_n !== 1'b1) $display("FAIL rst_we_n got %b exp 1", mem_we_n); else passed++;
        total++; if (mem_addr !== 18'h3FFFF) $display("FAIL rst_addr got %h exp 3ffff", mem_addr); else passed++;
        total++; if (mem_wdata !== 32'h0) $display("FAIL rst_wdata got %h exp 0", mem_wdata); else passed++;
        total++; if (mem_wr_size !== MEMORY_WIDTH_8) $display("FAIL rst_size got %b exp %b", mem_wr_size, MEMORY_WIDTH_8); else passed++;
        total++; if (grant_valid !== 1'b0 || grant_id !== 2'd0) $display("FAIL rst_grant got %b/%0d exp 0/0", grant_valid, grant_id); else passed++;
        @(negedge CLK21M);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK21M);
        total++; if (grant_valid !== 1'b0 || ch_ack !== 4'b0000) $display("FAIL rst_noslot got gv=%b ack=%b exp 0/0000", grant_valid, ch_ack); else passed++;
        do_slot();
        exp_ack[0] = 1'b1;
        total++; if (grant_valid !== 1'b1 || grant_id !== 2'd0) $display("FAIL rst_first got %b/%0d exp 1/0", grant_valid, grant_id); else passed++;
        total++; if (ch_ack !== exp_ack) $display("FAIL rst_first_ack got %b exp %b", ch_ack, exp_ack); else passed++;
        total++; if (mem_addr !== base_addr[0] || mem_we_n !== 1'b1) $display("FAIL rst_first_mem got %h/%b exp %h/1", mem_addr, mem_we_n, base_addr[0]); else passed++;
        @(negedge CLK21M);
        total++; if (grant_valid !== 1'b0) $display("FAIL pulse_width got %b exp 0", grant_valid); else passed++;
    endtask

    task automatic test_fixed_priority();
        rr_mode = 1'b0;
        slot_begin();
        ch_req[1] = ~ch_req[1];
        ch_req[3] = ~ch_req[3];
        slot_end();
        exp_ack[1] = ~exp_ack[1];
        total++; if (grant_valid !== 1'b1 || grant_id !== 2'd1) $display("FAIL fp_first got %b/%0d exp 1/1", grant_valid, grant_id); else passed++;
        total++; if (ch_ack !== exp_ack || mem_addr !== base_addr[1]) $display("FAIL fp_first_ack got %b/%h exp %b/%h", ch_ack, mem_addr, exp_ack, base_addr[1]); else passed++;
        do_slot();
        exp_ack[3] = ~exp_ack[3];
        total++; if (grant_valid !== 1'b1 || grant_id !== 2'd3) $display("FAIL fp_second got %b/%0d exp 1/3", grant_valid, grant_id); else passed++;
        total++; if (ch_ack !== exp_ack || mem_addr !== base_addr[3]) $display("FAIL fp_second_ack got %b/%h exp %b/%h", ch_ack, mem_addr, exp_ack, base_addr[3]); else passed++;
        do_slot();
        total++; if (grant_valid !== 1'b0 || mem_we_n !== 1'b1 || mem_addr !== base_addr[3]) $display("FAIL fp_idle got %b/%b/%h exp 0/1/%h", grant_valid, mem_we_n, mem_addr, base_addr[3]); else passed++;
    endtask

    task automatic test_round_robin();
        logic [1:0] order [8];
        order = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        ch_req[1] = ~ch_req[1];
        do_slot();
        exp_ack[1] = ~exp_ack[1];
        total++; if (grant_valid !== 1'b1 || grant_id !== 2'd1) $display("FAIL rr_setup got %b/%0d exp 1/1", grant_valid, grant_id); else passed++;
        rr_mode = 1'b1;
        ch_req  = ~ch_req;
        for (int k = 0; k < 8; k++) begin
            do_slot();
            exp_ack[order[k]] = ~exp_ack[order[k]];
            total++; if (grant_valid !== 1'b1 || grant_id !== order[k]) $display("FAIL rr_order[%0d] got %b/%0d exp 1/%0d", k, grant_valid, grant_id, order[k]); else passed++;
            total++; if (ch_ack !== exp_ack) $display("FAIL rr_ack[%0d] got %b exp %b", k, ch_ack, exp_ack); else passed++;
            if (k < 4) ch_req[order[k]] = ~ch_req[order[k]];
        end
        rr_mode = 1'b0;
    endtask

    task automatic test_reservation();
        ch_req[0] = ~ch_req[0];
        ch_req[3] = ~ch_req[3];
        disp_addr = 18'h2ABCD;
        sprt_addr = 18'h15555;
        for (int k = 0; k < 4; k++) begin
            slot_begin();
            disp_claim = (k < 3);
            sprt_claim = (k >= 1);
            slot_end();
            total++; if (grant_valid !== 1'b0 || mem_we_n !== 1'b1 || ch_ack !== exp_ack) $display("FAIL resv_nogrant[%0d] got %b/%b/%b exp 0/1/%b", k, grant_valid, mem_we_n, ch_ack, exp_ack); else passed++;
            total++; if (mem_addr !== ((k < 3) ? disp_addr : sprt_addr)) $display("FAIL resv_addr[%0d] got %h exp %h", k, mem_addr, (k < 3) ? disp_addr : sprt_addr); else passed++;
        end
        disp_claim = 1'b0;
        sprt_claim = 1'b0;
        do_slot();
        exp_ack[0] = ~exp_ack[0];
        total++; if (grant_valid !== 1'b1 || grant_id !== 2'd0) $display("FAIL resv_after got %b/%0d exp 1/0", grant_valid, grant_id); else passed++;
        do_slot();
        exp_ack[3] = ~exp_ack[3];
        total++; if (grant_valid !== 1'b1 || grant_id !== 2'd3 || ch_ack !== exp_ack) $display("FAIL resv_ch3 got %b/%0d/%b exp 1/3/%b", grant_valid, grant_id, ch_ack, exp_ack); else passed++;
    endtask

    task automatic test_starvation();
        logic [1:0] exp_id;
        ch_req[0] = ~ch_req[0];
        ch_req[2] = ~ch_req[2];
        for (int k = 0; k < 5; k++) begin
            do_slot();
            exp_id = (k == 3) ? 2'd2 : 2'd0;
            exp_ack[exp_id] = ~exp_ack[exp_id];
            total++; if (grant_valid !== 1'b1 || grant_id !== exp_id) $display("FAIL starve[%0d] got %b/%0d exp 1/%0d", k, grant_valid, grant_id, exp_id); else passed++;
            if (k < 3) ch_req[0] = ~ch_req[0];
        end
        total++; if (ch_ack !== exp_ack) $display("FAIL starve_ack got %b exp %b", ch_ack, exp_ack); else passed++;
    endtask

    task automatic test_write_path();
        set_ch(1, 1'b1, 18'h01234, 32'hA5A5A5A5, MEMORY_WIDTH_32);
        ch_req[1] = ~ch_req[1];
        do_slot();
        exp_ack[1] = ~exp_ack[1];
        total++; if (grant_valid !== 1'b1 || grant_id !== 2'd1) $display("FAIL wr_grant got %b/%0d exp 1/1", grant_valid, grant_id); else passed++;
        total++; if (mem_addr !== 18'h01234 || mem_wdata !== 32'hA5A5A5A5) $display("FAIL wr_bus got %h/%h exp 01234/a5a5a5a5", mem_addr, mem_wdata); else passed++;
        total++; if (mem_we_n !== 1'b0 || mem_wr_size !== MEMORY_WIDTH_32) $display("FAIL wr_ctl got %b/%b exp 0/%b", mem_we_n, mem_wr_size, MEMORY_WIDTH_32); else passed++;
        @(negedge CLK21M);
        total++; if (mem_we_n !== 1'b1 || mem_addr !== 18'h01234) $display("FAIL wr_release got %b/%h exp 1/01234", mem_we_n, mem_addr); else passed++;
        ch_req[2] = ~ch_req[2];
        ch_req[2] = ~ch_req[2];
        do_slot();
        total++; if (grant_valid !== 1'b0 || ch_ack !== exp_ack) $display("FAIL proto_err got %b/%b exp 0/%b", grant_valid, ch_ack, exp_ack); else passed++;
        ch_req[0] = ~ch_req[0];
        do_slot();
        exp_ack[0] = ~exp_ack[0];
        total++; if (mem_addr !== base_addr[0] || mem_we_n !== 1'b1) $display("FAIL rd_after_wr got %h/%b exp %h/1", mem_addr, mem_we_n, base_addr[0]); else passed++;
        total++; if (mem_wdata !== 32'hA5A5A5A5 || mem_wr_size !== MEMORY_WIDTH_32) $display("FAIL rd_hold got %h/%b exp a5a5a5a5/%b", mem_wdata, mem_wr_size, MEMORY_WIDTH_32); else passed++;
    endtask

    task automatic test_reset_midwrite();
        ch_req[1] = ~ch_req[1];
        do_slot();
        total++; if (mem_we_n !== 1'b0) $display("FAIL mid_wr_active got %b exp 0", mem_we_n); else passed++;
        RESET_N = 1'b0;
        ch_req  = '0;
        exp_ack = '0;
        #1;
        total++; if (mem_we_n !== 1'b1 || mem_addr !== 18'h3FFFF) $display("FAIL mid_rst_mem got %b/%h exp 1/3ffff", mem_we_n, mem_addr); else passed++;
        total++; if (ch_ack !== exp_ack || grant_valid !== 1'b0 || mem_wdata !== 32'h0) $display("FAIL mid_rst_state got %b/%b/%h exp 0000/0/0", ch_ack, grant_valid, mem_wdata); else passed++;
        @(negedge CLK21M);
        RESET_N = 1'b1;
    endtask

    initial begin
        base_addr = '{18'h01000, 18'h01111, 18'h01222, 18'h01333};
        dot_state  = 2'd0;
        rr_mode    = 1'b0;
        disp_claim = 1'b0;
        sprt_claim = 1'b0;
        disp_addr  = '0;
        sprt_addr  = '0;
        ch_we      = '0;
        ch_addr    = '0;
        ch_wdata   = '0;
        ch_wsize   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            set_ch(i, 1'b0, base_addr[i], 32'h10 * (i + 1), MEMORY_WIDTH_8);
        end
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_reservation();
        test_starvation();
        test_write_path();
        test_reset_midwrite();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
